key_store: RTL and testbench
============================

# key_store

Parametrised multi-slot key register for the cipher datapath. It loads keys byte-serially over a valid/ready port into one of NUM_KEYS slots. It then streams a selected slot's bytes cyclically, wrapping around, to the XOR/cipher stage over a second valid/ready port. Internal byte counters replace the external byte-select input.

## Interface
- DATA_W, 8, byte width in bits
- KEY_BYTES, 4, bytes per key (≥2)
- NUM_KEYS, 2, number of key slots (≥1)
- dclk  in  1  clock
- reset  in  1  synchronous, active-high; clock dclk
- load_start  in  1  pulse: begin loading slot load_slot
- load_slot  in  SW  target slot, SW = max(1, $clog2(NUM_KEYS))
- load_valid / load_ready  in / out  1  byte-load handshake
- load_data  in  DATA_W  key byte
- stream_start  in  1  pulse: begin streaming slot stream_slot
- stream_slot  in  SW  source slot
- stream_stop  in  1  pulse: end streaming
- ks_valid / ks_ready  out / in  1  keystream handshake
- ks_data  out  DATA_W  keystream byte (registered)
- key_valid  out  NUM_KEYS  per-slot "fully loaded" flag
- busy  out  1  state ≠ IDLE
- err  out  1  one-cycle pulse on a rejected command

## Operation
- FSM states: IDLE, LOAD, STREAM.
- IDLE + load_start, with load_slot < NUM_KEYS:
  - clear key_valid[load_slot] and the byte index.
  - Next state LOAD.
- IDLE + load_start, with load_slot out of range: pulse err, stay IDLE.
- IDLE + stream_start:
  - If stream_slot < NUM_KEYS and key_valid[stream_slot]: latch the slot, index 0, next state STREAM.
  - Otherwise: pulse err, stay IDLE.
- load_start and stream_start in the same cycle: load wins, stream_start is dropped with no err.
- LOAD:
  - load_ready = 1.
  - Each load_valid&&load_ready writes load_data to byte [idx*DATA_W +: DATA_W] of the slot, byte 0 first, then idx++.
  - On byte KEY_BYTES-1: set key_valid[slot], next state IDLE.
  - load_start, stream_start and stream_stop are ignored in LOAD.
- STREAM:
  - ks_valid = 1 and ks_data = slot byte idx.
  - On a transfer, idx advances; after KEY_BYTES-1 it wraps to 0.
  - stream_stop leads to IDLE next cycle.
  - If stream_stop coincides with a transfer, that byte counts as transferred.
  - Load and start commands are ignored in STREAM.
- Byte index width: max(1, $clog2(KEY_BYTES)). Compare for wrap explicitly; do not rely on counter overflow.

## Timing
- Reset values: state IDLE, all key storage 0, key_valid 0, load_ready 0, ks_valid 0, ks_data 0, busy 0, err 0.
- Reset mid-LOAD or mid-STREAM aborts and clears everything, same as power-on.
- load_start accepted at edge N → load_ready = 1 from N+1.
- Key of K bytes loaded back-to-back: key_valid rises and load_ready falls one cycle after the final handshake.
- stream_start accepted at edge N → ks_valid = 1 with byte 0 from N+1.
- ks_ready held high → one byte per cycle, no bubbles, including across the wrap.
- ks_valid=1, ks_ready=0: ks_data held stable.
- busy is registered and equals (state ≠ IDLE).
- err asserts the cycle after the rejected command.

## Configuration
- KEY_STORE_ZEROIZE_EN defined:
  - Adds input zeroize (1 bit).
  - Asserting it clears all key bytes and key_valid, forces IDLE, and drives outputs to reset values on the next edge.
  - Priority is below reset, above every other input.
- KEY_STORE_ZEROIZE_EN undefined:
  - Port absent.
  - Storage is cleared only by reset; an abandoned partial load only clears key_valid of its slot.

## Structure
- Package key_store_pkg:
  - state enum (IDLE/LOAD/STREAM).
  - function for slot/index width (max(1,$clog2(n))).
- Sub-module key_byte_counter: parametrised modulo-KEY_BYTES counter with clear, enable, and wrap flag.
  - Instantiated twice: load index and stream index.
- Key storage: NUM_KEYS × (KEY_BYTES*DATA_W) register array in the top level.

## Test plan
- Reset, then check outputs: all zero.
- Default params:
  - load slot 0 with 0x11,0x22,0x33,0x44 → key_valid=01.
  - stream slot 0, ks_ready=1 for 10 cycles → 11,22,33,44,11,22,33,44,11,22.
- Stream slot 1 before it is loaded → err pulse, busy=0, ks_valid=0.
- Back-pressure:
  - toggle ks_ready 1,0,0,1 → ks_data stays 0x22 while stalled.
  - no byte skipped or duplicated.
- Reload while busy:
  - load_start during STREAM is ignored.
  - stream_stop together with a handshake → byte counted, IDLE next cycle.
  - reload slot 0 with AA,BB,CC,DD → stream yields AA first.
- Reset after 2 of 4 load bytes → key_valid=00, storage 0, next load starts at byte 0.
- With KEY_STORE_ZEROIZE_EN: zeroize mid-STREAM → next cycle ks_valid=0, key_valid=00, stream_start on slot 0 → err.

Source files
------------

// File: rtl/key_store_pkg.sv
// Shared types and helpers for the key_store block.
package key_store_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    // max(1, $clog2(n)): a single slot or byte still needs a 1-bit select.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_byte_counter.sv
// Modulo-MODULUS byte index with synchronous clear and enable; wrap flags the last index.
module key_byte_counter #(
    parameter int MODULUS = 4,
    parameter int W       = 2
) (
    input  logic         dclk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    assign wrap = (count == LAST);

    always_ff @(posedge dclk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/key_store.sv
// Multi-slot key register: byte-serial load, cyclic keystream out.
// Optional KEY_STORE_ZEROIZE_EN adds a zeroize input that wipes all keys.
//
// state  | meaning
// IDLE   | waiting for load_start / stream_start
// LOAD   | accepting key bytes into load slot, byte 0 first
// STREAM | presenting selected slot bytes cyclically on ks_*
module key_store
    import key_store_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int KEY_BYTES = 4,
    parameter  int NUM_KEYS  = 2,
    localparam int SW        = idx_width(NUM_KEYS),
    localparam int IW        = idx_width(KEY_BYTES)
) (
    input  logic                dclk,
    input  logic                reset,
`ifdef KEY_STORE_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic                load_start,
    input  logic [SW-1:0]       load_slot,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                stream_start,
    input  logic [SW-1:0]       stream_slot,
    input  logic                stream_stop,
    output logic                ks_valid,
    input  logic                ks_ready,
    output logic [DATA_W-1:0]   ks_data,
    output logic [NUM_KEYS-1:0] key_valid,
    output logic                busy,
    output logic                err
);

    state_t                      state;
    logic [KEY_BYTES*DATA_W-1:0] keys [NUM_KEYS];
    logic [SW-1:0]               lslot;
    logic [SW-1:0]               sslot;

    logic          clear_all;
    logic          load_in_range, stream_ok;
    logic          load_go, stream_go;
    logic          load_hs, ks_hs;
    logic [IW-1:0] l_idx, s_idx, s_next;
    logic          l_wrap, s_wrap;

`ifdef KEY_STORE_ZEROIZE_EN
    assign clear_all = zeroize;
`else
    assign clear_all = 1'b0;
`endif

    assign load_in_range = 32'(load_slot) < NUM_KEYS;
    assign stream_ok     = (32'(stream_slot) < NUM_KEYS) && key_valid[stream_slot];
    // load_start has priority; a coincident stream_start is silently dropped
    assign load_go       = (state == IDLE) && load_start && load_in_range;
    assign stream_go     = (state == IDLE) && !load_start && stream_start && stream_ok;
    assign load_hs       = load_valid && load_ready;
    assign ks_hs         = ks_valid && ks_ready;
    assign s_next        = s_wrap ? '0 : s_idx + IW'(1);

    key_byte_counter #(.MODULUS(KEY_BYTES), .W(IW)) u_load_idx (
        .dclk  (dclk),
        .reset (reset),
        .clr   (clear_all | load_go),
        .en    (load_hs),
        .count (l_idx),
        .wrap  (l_wrap)
    );

    key_byte_counter #(.MODULUS(KEY_BYTES), .W(IW)) u_stream_idx (
        .dclk  (dclk),
        .reset (reset),
        .clr   (clear_all | stream_go),
        .en    (ks_hs),
        .count (s_idx),
        .wrap  (s_wrap)
    );

    always_ff @(posedge dclk) begin
        if (reset || clear_all) begin
            state      <= IDLE;
            lslot      <= '0;
            sslot      <= '0;
            key_valid  <= '0;
            load_ready <= 1'b0;
            ks_valid   <= 1'b0;
            ks_data    <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                keys[k] <= '0;
            end
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        if (load_in_range) begin
                            key_valid[load_slot] <= 1'b0;
                            lslot      <= load_slot;
                            load_ready <= 1'b1;
                            busy       <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (stream_start) begin
                        if (stream_ok) begin
                            sslot    <= stream_slot;
                            ks_data  <= keys[stream_slot][DATA_W-1:0];
                            ks_valid <= 1'b1;
                            busy     <= 1'b1;
                            state    <= STREAM;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        keys[lslot][l_idx*DATA_W +: DATA_W] <= load_data;
                        if (l_wrap) begin
                            key_valid[lslot] <= 1'b1;
                            load_ready       <= 1'b0;
                            busy             <= 1'b0;
                            state            <= IDLE;
                        end
                    end
                end
                STREAM: begin
                    if (ks_hs) begin
                        ks_data <= keys[sslot][s_next*DATA_W +: DATA_W];
                    end
                    if (stream_stop) begin
                        ks_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_store.sv
// Scoreboard bench for key_store: expected keystream bytes queued by stimulus, checked by a monitor.
module tb_key_store;

    logic       dclk = 1'b0;
    logic       reset = 1'b1;
`ifdef KEY_STORE_ZEROIZE_EN
    logic       zeroize = 1'b0;
`endif
    logic       load_start = 1'b0;
    logic [0:0] load_slot = '0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = '0;
    logic       stream_start = 1'b0;
    logic [0:0] stream_slot = '0;
    logic       stream_stop = 1'b0;
    logic       ks_valid;
    logic       ks_ready = 1'b0;
    logic [7:0] ks_data;
    logic [1:0] key_valid;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    key_store #(.DATA_W(8), .KEY_BYTES(4), .NUM_KEYS(2)) dut (
        .dclk         (dclk),
        .reset        (reset),
`ifdef KEY_STORE_ZEROIZE_EN
        .zeroize      (zeroize),
`endif
        .load_start   (load_start),
        .load_slot    (load_slot),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .stream_start (stream_start),
        .stream_slot  (stream_slot),
        .stream_stop  (stream_stop),
        .ks_valid     (ks_valid),
        .ks_ready     (ks_ready),
        .ks_data      (ks_data),
        .key_valid    (key_valid),
        .busy         (busy),
        .err          (err)
    );

    always #5 dclk = ~dclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer pops the next expected byte; a stall must hold the head byte.
    always @(negedge dclk) begin
        if (!reset && ks_valid) begin
            if (exp_q.size() == 0) begin
                if (ks_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL ks_unexpected: got 0x%0h expected no transfer", ks_data);
                end
            end else if (ks_ready) begin
                check("ks_byte", ks_data, exp_q.pop_front());
            end else begin
                check("ks_stall_hold", ks_data, exp_q[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic load_key(input logic [0:0] slot, input logic [31:0] k);
        load_start = 1'b1;
        load_slot  = slot;
        tick();
        load_start = 1'b0;
        check("load_ready_up", load_ready, 1);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = k[31-8*i -: 8];
            tick();
        end
        load_valid = 1'b0;
        check("load_ready_down", load_ready, 0);
        check("load_busy_down", busy, 0);
    endtask

    task automatic push_bytes(input logic [31:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(k[31-8*(i%4) -: 8]);
        end
    endtask

    task automatic stream_run(input logic [0:0] slot, input int n);
        stream_start = 1'b1;
        stream_slot  = slot;
        tick();
        stream_start = 1'b0;
        check("stream_busy", busy, 1);
        check("stream_valid", ks_valid, 1);
        ks_ready = 1'b1;
        repeat (n) tick();
        ks_ready    = 1'b0;
        stream_stop = 1'b1;
        tick();
        stream_stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_valid", ks_valid, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        check("rst_load_ready", load_ready, 0);
        check("rst_ks_valid", ks_valid, 0);
        check("rst_ks_data", ks_data, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);

        // basic load and cyclic stream with wrap
        load_key(1'b0, 32'h11223344);
        check("kv_after_load0", key_valid, 2'b01);
        push_bytes(32'h11223344, 10);
        stream_run(1'b0, 10);

        // stream an unloaded slot
        stream_start = 1'b1;
        stream_slot  = 1'b1;
        tick();
        stream_start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_ks_valid", ks_valid, 0);
        tick();
        check("err_single_cycle", err, 0);

        // back-pressure: ready 1,0,0,1,1,1
        push_bytes(32'h11223344, 4);
        stream_start = 1'b1;
        stream_slot  = 1'b0;
        tick();
        stream_start = 1'b0;
        ks_ready = 1'b1; tick();
        ks_ready = 1'b0; tick();
        check("bp_hold_22", ks_data, 8'h22);
        tick();
        check("bp_hold_22b", ks_data, 8'h22);
        ks_ready = 1'b1; repeat (3) tick();
        ks_ready    = 1'b0;
        stream_stop = 1'b1;
        tick();
        stream_stop = 1'b0;
        check("bp_queue_drained", exp_q.size(), 0);

        // load_start ignored during STREAM; stop coinciding with a transfer
        push_bytes(32'h11223344, 2);
        stream_start = 1'b1;
        stream_slot  = 1'b0;
        tick();
        stream_start = 1'b0;
        ks_ready   = 1'b1;
        load_start = 1'b1;
        load_slot  = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h99;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        check("ign_load_ready", load_ready, 0);
        check("ign_busy", busy, 1);
        check("ign_key_valid", key_valid, 2'b01);
        stream_stop = 1'b1;
        tick();
        stream_stop = 1'b0;
        ks_ready    = 1'b0;
        check("stophs_busy", busy, 0);
        check("stophs_valid", ks_valid, 0);
        check("stophs_queue", exp_q.size(), 0);

        // reload slot 0, stream restarts at byte 0
        load_key(1'b0, 32'hAABBCCDD);
        check("kv_after_reload", key_valid, 2'b01);
        push_bytes(32'hAABBCCDD, 2);
        stream_run(1'b0, 2);

        // reset in the middle of a load
        load_start = 1'b1;
        load_slot  = 1'b0;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hEE; tick();
        load_data  = 8'hFF; tick();
        load_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_key_valid", key_valid, 0);
        check("midrst_load_ready", load_ready, 0);
        check("midrst_busy", busy, 0);
        stream_start = 1'b1;
        stream_slot  = 1'b0;
        tick();
        stream_start = 1'b0;
        check("midrst_stream_err", err, 1);
        load_key(1'b1, 32'h01020304);
        check("kv_slot1", key_valid, 2'b10);
        push_bytes(32'h01020304, 5);
        stream_run(1'b1, 5);
        load_key(1'b0, 32'h55667788);
        check("kv_both", key_valid, 2'b11);
        push_bytes(32'h55667788, 4);
        stream_run(1'b0, 4);

`ifdef KEY_STORE_ZEROIZE_EN
        // zeroize mid-stream
        exp_q.push_back(8'h01);
        stream_start = 1'b1;
        stream_slot  = 1'b1;
        tick();
        stream_start = 1'b0;
        ks_ready = 1'b1; tick();
        ks_ready = 1'b0;
        zeroize  = 1'b1;
        tick();
        zeroize  = 1'b0;
        check("zero_ks_valid", ks_valid, 0);
        check("zero_key_valid", key_valid, 0);
        check("zero_busy", busy, 0);
        check("zero_ks_data", ks_data, 0);
        stream_start = 1'b1;
        stream_slot  = 1'b0;
        tick();
        stream_start = 1'b0;
        check("zero_stream_err", err, 1);
        check("zero_queue", exp_q.size(), 0);
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
